// File: rtl/fault_campaign_ctrl.sv
// Single-fault injection campaign sequencer for a residue-checked adder.
// Walks a fault-free run plus one run per fault site, classifies each outcome and keeps saturating tallies.
module fault_campaign_ctrl #(
    parameter int DATA_W  = 4,
    parameter int N_SITES = 75,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 16,
    localparam int SITE_W = $clog2(N_SITES + 1),
    localparam int WAIT_W = $clog2(SETTLE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              op_cin,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    output logic              dut_carry_in,
    output logic [N_SITES-1:0] err_vec,
    input  logic [DATA_W-1:0] dut_sum,
    input  logic              dut_carry_out,
    input  logic              dut_err_detected,
    output logic              busy,
    output logic              done,
    output logic              golden_fail,
    output logic              result_valid,
    output logic [SITE_W-1:0] result_site,
    output logic [1:0]        result_class,
    output logic [CNT_W-1:0]  cnt_masked,
    output logic [CNT_W-1:0]  cnt_detected,
    output logic [CNT_W-1:0]  cnt_silent,
    output logic [CNT_W-1:0]  cnt_false_alarm
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
    typedef enum logic [1:0] {CLS_MASKED, CLS_DETECTED, CLS_SILENT, CLS_FALSE_ALARM} class_t;

    localparam logic [SITE_W-1:0] LAST_SITE = SITE_W'(N_SITES);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [SITE_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DATA_W:0]    golden_q, golden_d;
    logic [DATA_W-1:0]  a_d, b_d;
    logic               cin_d;
    logic [N_SITES-1:0] err_vec_d;
    logic               gfail_d;
    logic               rv_d;
    logic [SITE_W-1:0]  site_d;
    class_t             class_q, class_d;
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];

    logic   ok;
    class_t outcome;

    // The sum and carry together must equal the full-width golden value.
    assign ok      = ({dut_carry_out, dut_sum} == golden_q);
    assign outcome = ok ? (dut_err_detected ? CLS_FALSE_ALARM : CLS_MASKED)
                        : (dut_err_detected ? CLS_DETECTED    : CLS_SILENT);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        golden_d  = golden_q;
        a_d       = dut_a;
        b_d       = dut_b;
        cin_d     = dut_carry_in;
        err_vec_d = err_vec;
        gfail_d   = golden_fail;
        rv_d      = 1'b0;
        site_d    = result_site;
        class_d   = class_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = op_a;
                    b_d       = op_b;
                    cin_d     = op_cin;
                    golden_d  = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, op_cin};
                    for (int i = 0; i < 4; i++) cnt_d[i] = '0;
                    gfail_d   = 1'b0;
                    idx_d     = '0;
                    wait_d    = WAIT_LOAD;
                    err_vec_d = '0;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                wait_d = wait_q - WAIT_W'(1);
                if (wait_q == WAIT_W'(1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                rv_d    = 1'b1;
                site_d  = idx_q;
                class_d = outcome;
                if (cnt_q[outcome] != CNT_MAX) cnt_d[outcome] = cnt_q[outcome] + CNT_W'(1);
                if (idx_q == '0 && outcome != CLS_MASKED) begin
                    // A broken reference run makes every faulted run meaningless.
                    gfail_d   = 1'b1;
                    err_vec_d = '0;
                    state_d   = S_DONE;
                end else if (idx_q == LAST_SITE) begin
                    err_vec_d = '0;
                    state_d   = S_DONE;
                end else begin
                    idx_d     = idx_q + SITE_W'(1);
                    wait_d    = WAIT_LOAD;
                    err_vec_d = N_SITES'(1) << idx_q;
                    state_d   = S_SETTLE;
                end
            end
            S_DONE: begin
                err_vec_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            wait_q       <= '0;
            golden_q     <= '0;
            dut_a        <= '0;
            dut_b        <= '0;
            dut_carry_in <= 1'b0;
            err_vec      <= '0;
            golden_fail  <= 1'b0;
            result_valid <= 1'b0;
            result_site  <= '0;
            class_q      <= CLS_MASKED;
            // NOTE: the four tallies are a tiny register file, so they are reset like any other flop.
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            golden_q     <= golden_d;
            dut_a        <= a_d;
            dut_b        <= b_d;
            dut_carry_in <= cin_d;
            err_vec      <= err_vec_d;
            golden_fail  <= gfail_d;
            result_valid <= rv_d;
            result_site  <= site_d;
            class_q      <= class_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign result_class    = class_q;
    assign cnt_masked      = cnt_q[CLS_MASKED];
    assign cnt_detected    = cnt_q[CLS_DETECTED];
    assign cnt_silent      = cnt_q[CLS_SILENT];
    assign cnt_false_alarm = cnt_q[CLS_FALSE_ALARM];

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: a per-site fault table drives a behavioural adder model,
// and a cycle-count reference model predicts every controller output each cycle.
module tb_fault_campaign_ctrl;

    localparam int DW  = 4;
    localparam int NS  = 75;
    localparam int ST  = 2;
    localparam int CW  = 16;
    localparam int SW  = $clog2(NS + 1);
    localparam int NS2 = 8;
    localparam int CW2 = 2;
    localparam int SW2 = $clog2(NS2 + 1);
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [DW-1:0] op_a, op_b;
    logic          op_cin;
    logic [DW-1:0] dut_a, dut_b, dut_sum;
    logic          dut_carry_in, dut_carry_out, dut_err_detected;
    logic [NS-1:0] err_vec;
    logic          busy, done, golden_fail, result_valid;
    logic [SW-1:0] result_site;
    logic [1:0]    result_class;
    logic [CW-1:0] cnt_masked, cnt_detected, cnt_silent, cnt_false_alarm;

    logic           s_start;
    logic [DW-1:0]  s_dut_a, s_dut_b, s_dut_sum;
    logic           s_dut_cin, s_dut_cout;
    logic [NS2-1:0] s_err_vec;
    logic           s_busy, s_done, s_gfail, s_rv;
    logic [SW2-1:0] s_rsite;
    logic [1:0]     s_rclass;
    logic [CW2-1:0] s_cnt_m, s_cnt_d, s_cnt_s, s_cnt_f;

    fault_campaign_ctrl #(.DATA_W(DW), .N_SITES(NS), .SETTLE(ST), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .dut_a(dut_a), .dut_b(dut_b), .dut_carry_in(dut_carry_in), .err_vec(err_vec),
        .dut_sum(dut_sum), .dut_carry_out(dut_carry_out), .dut_err_detected(dut_err_detected),
        .busy(busy), .done(done), .golden_fail(golden_fail), .result_valid(result_valid),
        .result_site(result_site), .result_class(result_class), .cnt_masked(cnt_masked),
        .cnt_detected(cnt_detected), .cnt_silent(cnt_silent), .cnt_false_alarm(cnt_false_alarm)
    );

    fault_campaign_ctrl #(.DATA_W(DW), .N_SITES(NS2), .SETTLE(ST), .CNT_W(CW2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op_a(4'd3), .op_b(4'd5), .op_cin(1'b1),
        .dut_a(s_dut_a), .dut_b(s_dut_b), .dut_carry_in(s_dut_cin), .err_vec(s_err_vec),
        .dut_sum(s_dut_sum), .dut_carry_out(s_dut_cout), .dut_err_detected(1'b0),
        .busy(s_busy), .done(s_done), .golden_fail(s_gfail), .result_valid(s_rv),
        .result_site(s_rsite), .result_class(s_rclass), .cnt_masked(s_cnt_m),
        .cnt_detected(s_cnt_d), .cnt_silent(s_cnt_s), .cnt_false_alarm(s_cnt_f)
    );

    // Ideal adder for the small instance; its fault vector is ignored.
    assign {s_dut_cout, s_dut_sum} = {1'b0, s_dut_a} + {1'b0, s_dut_b} + {{DW{1'b0}}, s_dut_cin};

    // Per-site fault behaviour: bit0 flips sum[0], bit1 raises the flag, bit2 flips carry_out.
    logic [2:0]  kind [0:NS];
    logic [2:0]  cur_kind;
    logic [DW:0] cur_res;

    function automatic int site_of(input logic [NS-1:0] v);
        int s = 0;
        for (int i = NS - 1; i >= 0; i--) if (v[i]) s = i + 1;
        return s;
    endfunction

    always_comb begin
        cur_kind = kind[site_of(err_vec)];
        cur_res  = {1'b0, dut_a} + {1'b0, dut_b} + {{DW{1'b0}}, dut_carry_in};
        if (cur_kind[0]) cur_res[0]  = ~cur_res[0];
        if (cur_kind[2]) cur_res[DW] = ~cur_res[DW];
        dut_sum          = cur_res[DW-1:0];
        dut_carry_out    = cur_res[DW];
        dut_err_detected = cur_kind[1];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome a site must produce: any corruption makes the result wrong; the flag is independent.
    function automatic int classify(input logic [2:0] k);
        bit wrong = k[0] || k[2];
        if (!wrong) return k[1] ? 3 : 0;
        return k[1] ? 1 : 2;
    endfunction

    // Reference model: campaign position is just a cycle count since the accepted start.
    bit            m_active = 0, m_in_done = 0, m_gfail = 0, m_rv = 0;
    int            m_cyc = 0, m_rsite = 0, m_rclass = 0;
    int            m_cnt [4] = '{0, 0, 0, 0};
    logic [DW-1:0] m_a = '0, m_b = '0;
    logic          m_cin = 1'b0;

    task automatic model_step();
        int k, cls;
        if (!rst_n) begin
            m_active = 0; m_in_done = 0; m_gfail = 0; m_rv = 0;
            m_cyc = 0; m_rsite = 0; m_rclass = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_a = '0; m_b = '0; m_cin = 1'b0;
            return;
        end
        m_rv = 0;
        if (m_active) begin
            if (m_in_done) begin
                m_active = 0;
                m_in_done = 0;
                m_cyc = 0;
            end else begin
                if (m_cyc % (ST + 1) == 0) begin
                    k   = m_cyc / (ST + 1) - 1;
                    cls = classify(kind[k]);
                    m_rv = 1; m_rsite = k; m_rclass = cls;
                    if (m_cnt[cls] < CMAX) m_cnt[cls]++;
                    if (k == 0 && cls != 0) begin
                        m_gfail = 1;
                        m_in_done = 1;
                    end else if (k == NS) begin
                        m_in_done = 1;
                    end
                end
                m_cyc++;
            end
        end else if (start === 1'b1) begin
            m_a = op_a; m_b = op_b; m_cin = op_cin;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_gfail = 0;
            m_active = 1;
            m_cyc = 1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    task automatic compare();
        int site;
        logic [NS-1:0] ev;
        site = (m_cyc > 0) ? (m_cyc - 1) / (ST + 1) : 0;
        ev = '0;
        if (m_active && !m_in_done && site > 0) ev[site-1] = 1'b1;
        check("err_vec", err_vec, ev);
        check("busy", busy, m_active);
        check("done", done, m_in_done);
        check("golden_fail", golden_fail, m_gfail);
        check("result_valid", result_valid, m_rv);
        check("result_site", result_site, m_rsite);
        check("result_class", result_class, m_rclass);
        check("dut_ops", {dut_a, dut_b, dut_carry_in}, {m_a, m_b, m_cin});
        check("cnt_masked", cnt_masked, m_cnt[0]);
        check("cnt_detected", cnt_detected, m_cnt[1]);
        check("cnt_silent", cnt_silent, m_cnt[2]);
        check("cnt_false_alarm", cnt_false_alarm, m_cnt[3]);
    endtask

    initial forever begin
        @(negedge clk);
        compare();
    end

    int obs_class [0:NS];

    // Runs one campaign from IDLE; lat counts cycles from the accepting edge to the done cycle.
    task automatic run_campaign(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                                output int lat, output int pulses);
        for (int i = 0; i <= NS; i++) obs_class[i] = -1;
        @(negedge clk);
        op_a = a; op_b = b; op_cin = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        pulses = 0;
        while (done !== 1'b1 && lat < 2000) begin
            if (result_valid === 1'b1) begin pulses++; obs_class[result_site] = result_class; end
            @(negedge clk);
            lat++;
        end
        if (result_valid === 1'b1) begin pulses++; obs_class[result_site] = result_class; end
        if (done !== 1'b1) check("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic clear_kinds();
        for (int i = 0; i <= NS; i++) kind[i] = 3'b000;
    endtask

    initial begin
        int lat, pulses, dones, guard;
        rst_n = 1'b0; start = 1'b0; s_start = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;
        clear_kinds();
        #12;
        check("reset_err_vec", err_vec, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_cnt", {cnt_masked, cnt_detected, cnt_silent, cnt_false_alarm}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ideal adder: every site masked, 76 results, done at 76*3+1.
        run_campaign(4'd9, 4'd1, 1'b0, lat, pulses);
        check("ideal_latency", lat, 229);
        check("ideal_pulses", pulses, 76);
        check("ideal_masked", cnt_masked, 76);
        check("model_masked", m_cnt[0], 76);
        check("ideal_other", {cnt_detected, cnt_silent, cnt_false_alarm}, '0);
        check("ideal_last_site", obs_class[75], 0);

        // err_vec[2] corrupts the sum and flags it.
        kind[3] = 3'b011;
        run_campaign(4'd9, 4'd1, 1'b0, lat, pulses);
        check("det_count", cnt_detected, 1);
        check("det_masked", cnt_masked, 75);
        check("det_site3_class", obs_class[3], 1);

        // err_vec[6] silently corrupts carry_out; err_vec[10] flags a correct result.
        clear_kinds();
        kind[7]  = 3'b100;
        kind[11] = 3'b010;
        run_campaign(4'd9, 4'd1, 1'b0, lat, pulses);
        check("silent_count", cnt_silent, 1);
        check("false_alarm_count", cnt_false_alarm, 1);
        check("mixed_masked", cnt_masked, 74);
        check("silent_site7", obs_class[7], 2);
        check("false_alarm_site11", obs_class[11], 3);

        // Always-flagging adder: the reference run fails and the campaign stops.
        for (int i = 0; i <= NS; i++) kind[i] = 3'b010;
        run_campaign(4'd9, 4'd1, 1'b0, lat, pulses);
        check("gfail_flag", golden_fail, 1'b1);
        check("gfail_false_alarm", cnt_false_alarm, 1);
        check("gfail_pulses", pulses, 1);
        check("gfail_latency", lat, 4);
        check("gfail_site0", obs_class[0], 3);

        // Re-start at site 20 is ignored; reset at site 40 aborts asynchronously.
        clear_kinds();
        @(negedge clk);
        op_a = 4'd7; op_b = 4'd12; op_cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        op_a = 4'd1; op_b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ignored_busy", busy, 1'b1);
        repeat (60) @(negedge clk);
        #2;
        check("abort_err_vec_live", err_vec != '0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_err_vec", err_vec, '0);
        check("abort_cnt", {cnt_masked, cnt_detected, cnt_silent, cnt_false_alarm}, '0);
        check("abort_busy_done", {busy, done}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_campaign(4'd15, 4'd15, 1'b1, lat, pulses);
        check("post_reset_masked", cnt_masked, 76);
        check("post_reset_latency", lat, 229);

        // Random operands and random per-site fault behaviour.
        for (int r = 0; r < 6; r++) begin
            for (int i = 1; i <= NS; i++) kind[i] = 3'($urandom_range(0, 7));
            kind[0] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            run_campaign(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), lat, pulses);
            check("rand_latency", lat, (classify(kind[0]) == 0) ? 229 : 4);
            check("rand_pulses", pulses, (classify(kind[0]) == 0) ? 76 : 1);
        end

        // start held high through DONE re-arms exactly once it is back in IDLE.
        clear_kinds();
        dones = 0;
        @(negedge clk);
        op_a = 4'd4; op_b = 4'd6; op_cin = 1'b0; start = 1'b1;
        repeat (240) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 600) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            guard++;
        end
        if (busy === 1'b1) check("hold_start_timeout", 1'b0, 1'b1);
        check("hold_start_dones", dones, 2);

        // Small instance: 9 masked results saturate a 2-bit counter at 3.
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        lat = 1;
        while (s_done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (s_done !== 1'b1) check("small_done_timeout", 1'b0, 1'b1);
        check("small_latency", lat, 28);
        check("small_saturate", s_cnt_m, 3);
        check("small_other", {s_cnt_d, s_cnt_s, s_cnt_f, s_gfail}, '0);
        @(negedge clk);
        check("small_hold", {s_busy, s_cnt_m}, {1'b0, 2'd3});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
